// File: rtl/lsu_pkg.sv
// Shared definitions for the load-store unit: address map, access widths
// and the byte-enable merge used by the memory-mapped output registers.
package lsu_pkg;

    localparam logic [31:0] DMEM_BASE  = 32'h0000_2000;
    localparam logic [31:0] DMEM_LIMIT = 32'h0000_3FFF;
    localparam logic [31:0] LEDR_ADDR  = 32'h0000_7000;
    localparam logic [31:0] LEDG_ADDR  = 32'h0000_7010;
    localparam logic [31:0] HEXL_ADDR  = 32'h0000_7020;
    localparam logic [31:0] HEXH_ADDR  = 32'h0000_7024;
    localparam logic [31:0] LCD_ADDR   = 32'h0000_7030;
    localparam logic [31:0] SW_ADDR    = 32'h0000_7800;
    localparam logic [31:0] BTN_ADDR   = 32'h0000_7810;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_op_e;

    function automatic logic [31:0] merge_be(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  be
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    // I/O registers are word-wide, so any byte inside the word hits them
    function automatic logic hit(
        input logic [31:0] addr,
        input logic [31:0] reg_addr
    );
        return addr[31:2] == reg_addr[31:2];
    endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Byte-enabled data memory: asynchronous read, synchronous write.
module lsu_dmem #(
    parameter int WORDS = 2048,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          wren,
    input  logic [3:0]    byte_en,
    input  logic [AW-1:0] word_addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (wren) begin
            for (int i = 0; i < 4; i++)
                if (byte_en[i])
                    mem[word_addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata = mem[word_addr];

endmodule

// File: rtl/lsu.sv
// Load-store unit: data memory plus memory-mapped LED/HEX/LCD/switch/button I/O.
// Define LSU_SYNC_IN_EN to pass switches and buttons through a 2-flop synchronizer.
module lsu
    import lsu_pkg::*;
#(
    parameter int DMEM_WORDS = 2048
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_lsu_op,
    input  logic [31:0] i_io_sw,
    input  logic [3:0]  i_io_btn,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [31:0] o_io_hexl,
    output logic [31:0] o_io_hexh,
    output logic [31:0] o_io_lcd,
    output logic        o_misalign
);

    localparam int DAW = $clog2(DMEM_WORDS);

    lsu_op_e     op;
    logic        is_byte;
    logic        is_half;
    logic        is_uns;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        store_en;
    logic        sel_dmem;
    logic        sel_ledr;
    logic        sel_ledg;
    logic        sel_hexl;
    logic        sel_hexh;
    logic        sel_lcd;
    logic        sel_sw;
    logic        sel_btn;
    logic [31:0] dmem_rdata;
    logic [31:0] rd_word;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] sw_q;
    logic [3:0]  btn_q;

    assign op = lsu_op_e'(i_lsu_op);

    // Reserved encodings fall through to a word access
    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        is_uns  = 1'b0;
        case (op)
            LSU_B:   is_byte = 1'b1;
            LSU_BU: begin
                is_byte = 1'b1;
                is_uns  = 1'b1;
            end
            LSU_H:   is_half = 1'b1;
            LSU_HU: begin
                is_half = 1'b1;
                is_uns  = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_misalign = (is_half & i_lsu_addr[0])
                      | (~is_byte & ~is_half & (i_lsu_addr[1:0] != 2'b00));

    always_comb begin
        be    = 4'b1111;
        wdata = i_st_data;
        if (is_byte) begin
            be    = 4'b0001 << i_lsu_addr[1:0];
            wdata = {4{i_st_data[7:0]}};
        end else if (is_half) begin
            be    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{i_st_data[15:0]}};
        end
    end

    assign sel_dmem = (i_lsu_addr >= DMEM_BASE) && (i_lsu_addr <= DMEM_LIMIT);
    assign sel_ledr = hit(i_lsu_addr, LEDR_ADDR);
    assign sel_ledg = hit(i_lsu_addr, LEDG_ADDR);
    assign sel_hexl = hit(i_lsu_addr, HEXL_ADDR);
    assign sel_hexh = hit(i_lsu_addr, HEXH_ADDR);
    assign sel_lcd  = hit(i_lsu_addr, LCD_ADDR);
    assign sel_sw   = hit(i_lsu_addr, SW_ADDR);
    assign sel_btn  = hit(i_lsu_addr, BTN_ADDR);

    // Reset gating also blocks a store whose edge meets reset assertion
    assign store_en = i_lsu_wren & ~o_misalign & i_rst_n;

    lsu_dmem #(
        .WORDS (DMEM_WORDS)
    ) u_dmem (
        .clk       (i_clk),
        .wren      (store_en & sel_dmem),
        .byte_en   (be),
        .word_addr (i_lsu_addr[DAW+1:2]),
        .wdata     (wdata),
        .rdata     (dmem_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_io_ledr <= '0;
            o_io_ledg <= '0;
            o_io_hexl <= '0;
            o_io_hexh <= '0;
            o_io_lcd  <= '0;
        end else if (store_en) begin
            if (sel_ledr) o_io_ledr <= merge_be(o_io_ledr, wdata, be);
            if (sel_ledg) o_io_ledg <= merge_be(o_io_ledg, wdata, be);
            if (sel_hexl) o_io_hexl <= merge_be(o_io_hexl, wdata, be);
            if (sel_hexh) o_io_hexh <= merge_be(o_io_hexh, wdata, be);
            if (sel_lcd)  o_io_lcd  <= merge_be(o_io_lcd, wdata, be);
        end
    end

`ifdef LSU_SYNC_IN_EN
    logic [31:0] sw_m;
    logic [3:0]  btn_m;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sw_m  <= '0;
            sw_q  <= '0;
            btn_m <= '0;
            btn_q <= '0;
        end else begin
            sw_m  <= i_io_sw;
            sw_q  <= sw_m;
            btn_m <= i_io_btn;
            btn_q <= btn_m;
        end
    end
`else
    assign sw_q  = i_io_sw;
    assign btn_q = i_io_btn;
`endif

    always_comb begin
        rd_word = '0;
        unique case (1'b1)
            sel_dmem: rd_word = dmem_rdata;
            sel_ledr: rd_word = o_io_ledr;
            sel_ledg: rd_word = o_io_ledg;
            sel_hexl: rd_word = o_io_hexl;
            sel_hexh: rd_word = o_io_hexh;
            sel_lcd:  rd_word = o_io_lcd;
            sel_sw:   rd_word = sw_q;
            sel_btn:  rd_word = {28'b0, btn_q};
            default:  rd_word = '0;
        endcase
    end

    assign lane_b = rd_word[{i_lsu_addr[1:0], 3'b000} +: 8];
    assign lane_h = i_lsu_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        o_ld_data = '0;
        if (!o_misalign) begin
            if (is_byte)
                o_ld_data = {{24{~is_uns & lane_b[7]}}, lane_b};
            else if (is_half)
                o_ld_data = {{16{~is_uns & lane_h[15]}}, lane_h};
            else
                o_ld_data = rd_word;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table plus reset,
// same-cycle read/write and input-latency sequences.
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        wren;
    logic [2:0]  op;
    logic [31:0] io_sw;
    logic [3:0]  io_btn;
    logic [31:0] ld_data;
    logic [31:0] ledr;
    logic [31:0] ledg;
    logic [31:0] hexl;
    logic [31:0] hexh;
    logic [31:0] lcd;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    lsu dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_lsu_addr (addr),
        .i_st_data  (st_data),
        .i_lsu_wren (wren),
        .i_lsu_op   (op),
        .i_io_sw    (io_sw),
        .i_io_btn   (io_btn),
        .o_ld_data  (ld_data),
        .o_io_ledr  (ledr),
        .o_io_ledg  (ledg),
        .o_io_hexl  (hexl),
        .o_io_hexh  (hexh),
        .o_io_lcd   (lcd),
        .o_misalign (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wren;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic        chk;
        logic [31:0] exp_ld;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", nm, got, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [31:0] e_r,
                              input logic [31:0] e_g, input logic [31:0] e_hl,
                              input logic [31:0] e_hh, input logic [31:0] e_l);
        check({tag, "_ledr"}, ledr, e_r);
        check({tag, "_ledg"}, ledg, e_g);
        check({tag, "_hexl"}, hexl, e_hl);
        check({tag, "_hexh"}, hexh, e_hh);
        check({tag, "_lcd"}, lcd, e_l);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        addr    = '0;
        st_data = '0;
        wren    = 1'b0;
        op      = W;
        io_sw   = 32'h0000_A5A5;
        io_btn  = 4'b1010;

        tick();
        check_regs("reset", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b1;
        repeat (3) tick();

        // wren, op, addr, data, chk, exp_ld, exp_mis
        vecs.push_back('{1'b1, W,  32'h2004, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0});
        vecs.push_back('{1'b0, B,  32'h2007, 32'h0,        1'b1, 32'hFFFFFFDE, 1'b0});
        vecs.push_back('{1'b0, BU, 32'h2007, 32'h0,        1'b1, 32'h000000DE, 1'b0});
        vecs.push_back('{1'b0, H,  32'h2006, 32'h0,        1'b1, 32'hFFFFDEAD, 1'b0});
        vecs.push_back('{1'b0, HU, 32'h2006, 32'h0,        1'b1, 32'h0000DEAD, 1'b0});
        vecs.push_back('{1'b0, W,  32'h2004, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, B,  32'h2004, 32'h0,        1'b1, 32'hFFFFFFEF, 1'b0});
        vecs.push_back('{1'b0, BU, 32'h2005, 32'h0,        1'b1, 32'h000000BE, 1'b0});
        vecs.push_back('{1'b0, H,  32'h2004, 32'h0,        1'b1, 32'hFFFFBEEF, 1'b0});
        vecs.push_back('{1'b1, W,  32'h2000, 32'h11223344, 1'b0, 32'h0,        1'b0});
        vecs.push_back('{1'b1, W,  32'h2002, 32'h00000055, 1'b1, 32'h0,        1'b1});
        vecs.push_back('{1'b0, W,  32'h2000, 32'h0,        1'b1, 32'h11223344, 1'b0});
        vecs.push_back('{1'b1, H,  32'h2001, 32'h0000FFFF, 1'b1, 32'h0,        1'b1});
        vecs.push_back('{1'b0, W,  32'h2000, 32'h0,        1'b1, 32'h11223344, 1'b0});
        vecs.push_back('{1'b0, B,  32'h2003, 32'h0,        1'b1, 32'h00000011, 1'b0});
        vecs.push_back('{1'b0, HU, 32'h2002, 32'h0,        1'b1, 32'h00001122, 1'b0});
        vecs.push_back('{1'b0, 3'b111, 32'h2000, 32'h0,    1'b1, 32'h11223344, 1'b0});
        vecs.push_back('{1'b0, 3'b011, 32'h2001, 32'h0,    1'b1, 32'h0,        1'b1});
        vecs.push_back('{1'b1, W,  32'h5000, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{1'b0, W,  32'h5000, 32'h0,        1'b1, 32'h0,        1'b0});
        vecs.push_back('{1'b1, H,  32'h7002, 32'hABCD1234, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{1'b0, W,  32'h7000, 32'h0,        1'b1, 32'h12340000, 1'b0});
        vecs.push_back('{1'b1, B,  32'h7000, 32'h000055AA, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{1'b0, W,  32'h7000, 32'h0,        1'b1, 32'h123400AA, 1'b0});
        vecs.push_back('{1'b0, HU, 32'h7002, 32'h0,        1'b1, 32'h00001234, 1'b0});
        vecs.push_back('{1'b0, B,  32'h7000, 32'h0,        1'b1, 32'hFFFFFFAA, 1'b0});
        vecs.push_back('{1'b0, BU, 32'h7003, 32'h0,        1'b1, 32'h00000012, 1'b0});
        vecs.push_back('{1'b1, W,  32'h7010, 32'hCAFEF00D, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{1'b1, W,  32'h7020, 32'h01020304, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{1'b1, W,  32'h7024, 32'h05060708, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{1'b1, B,  32'h7025, 32'h00000077, 1'b1, 32'h00000007, 1'b0});
        vecs.push_back('{1'b0, W,  32'h7024, 32'h0,        1'b1, 32'h05067708, 1'b0});
        vecs.push_back('{1'b1, W,  32'h7030, 32'h80000041, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{1'b1, W,  32'h7031, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1});
        vecs.push_back('{1'b1, W,  32'h7800, 32'hFFFFFFFF, 1'b1, 32'h0000A5A5, 1'b0});
        vecs.push_back('{1'b0, W,  32'h7800, 32'h0,        1'b1, 32'h0000A5A5, 1'b0});
        vecs.push_back('{1'b0, B,  32'h7800, 32'h0,        1'b1, 32'hFFFFFFA5, 1'b0});
        vecs.push_back('{1'b0, BU, 32'h7801, 32'h0,        1'b1, 32'h000000A5, 1'b0});
        vecs.push_back('{1'b0, H,  32'h7800, 32'h0,        1'b1, 32'hFFFFA5A5, 1'b0});
        vecs.push_back('{1'b1, W,  32'h7810, 32'hFFFFFFFF, 1'b1, 32'h0000000A, 1'b0});
        vecs.push_back('{1'b0, BU, 32'h7810, 32'h0,        1'b1, 32'h0000000A, 1'b0});

        foreach (vecs[i]) begin
            wren    = vecs[i].wren;
            op      = vecs[i].op;
            addr    = vecs[i].addr;
            st_data = vecs[i].data;
            #2;
            if (vecs[i].chk)
                check($sformatf("vec%0d_ld", i), ld_data, vecs[i].exp_ld);
            check($sformatf("vec%0d_mis", i), {31'b0, misalign},
                  {31'b0, vecs[i].exp_mis});
            tick();
        end
        wren = 1'b0;

        check_regs("io", 32'h123400AA, 32'hCAFEF00D, 32'h01020304,
                   32'h05067708, 32'h80000041);

        // Same-cycle store then load of one DMEM word
        wren = 1'b1; op = W; addr = 32'h2008; st_data = 32'h12345678;
        tick();
        st_data = 32'h0BADF00D;
        #2;
        check("rw_same_cycle_old", ld_data, 32'h12345678);
        tick();
        wren = 1'b0;
        #2;
        check("rw_next_cycle_new", ld_data, 32'h0BADF00D);
        tick();

        // Asynchronous reset clears registers without a clock edge
        rst_n = 1'b0;
        #1;
        check_regs("async_rst", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        wren = 1'b1; op = W; addr = 32'h7000; st_data = 32'hFFFFFFFF;
        tick();
        check("rst_store_blocked", ledr, 32'h0);
        wren = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();

        // Switch input latency into the load path
        addr = 32'h7800; op = W; io_sw = 32'h00001234;
        #2;
`ifdef LSU_SYNC_IN_EN
        check("sw_lat0", ld_data, 32'h0000A5A5);
        tick();
        check("sw_lat1", ld_data, 32'h0000A5A5);
        tick();
        check("sw_lat2", ld_data, 32'h00001234);
`else
        check("sw_lat0", ld_data, 32'h00001234);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load-store unit of the single-cycle RV32I core. It is the responder for the memory-control signals the decoder produces: it executes stores on the clock edge and returns load data combinationally in the same cycle. It owns the data memory and the memory-mapped I/O registers: red LEDs, green LEDs, seven-segment displays, LCD, switches and buttons. It sits between the ALU result/rs2 path and the write-back mux (wb_sel = 01).

## Interface
- DMEM_WORDS, 2048: data memory depth in 32-bit words (8 KiB); must be a power of two and no larger than 2048.
- i_clk  in  1  core clock; all state updates on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_lsu_addr  in  32  byte address (ALU result)
- i_st_data  in  32  store data (rs2)
- i_lsu_wren  in  1  store strobe (decoder mem_wren)
- i_lsu_op  in  3  instr[14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_io_sw  in  32  switch inputs
- i_io_btn  in  4  push-button inputs
- o_ld_data  out  32  load result, extended per i_lsu_op
- o_io_ledr  out  32  red LED register
- o_io_ledg  out  32  green LED register
- o_io_hexl  out  32  HEX3..HEX0, 7 bits per byte, bit 7 of each byte unused
- o_io_hexh  out  32  HEX7..HEX4, same layout
- o_io_lcd  out  32  LCD control/data register
- o_misalign  out  1  current access is misaligned (combinational)

## Operation
- Address map, decoded on the full 32-bit address:
  - DMEM: 0x0000_2000–0x0000_3FFF
  - LEDR: 0x7000
  - LEDG: 0x7010
  - HEXL: 0x7020
  - HEXH: 0x7024
  - LCD: 0x7030
  - SW: 0x7800 (read-only)
  - BTN: 0x7810 (read-only, zero-extended)
- Output registers accept byte, half and word stores through byte enables. They read back their current value.
- Alignment: H/HU need addr[0]=0; W needs addr[1:0]=00. B/BU are always aligned.
- When o_misalign=1:
  - the store is suppressed;
  - o_ld_data=0.
- Unmapped address: stores are ignored and o_ld_data=0. This is not an error.
- Store to SW or BTN: ignored.
- Byte lanes follow addr[1:0]; store data is taken from the low bits of i_st_data.
  - SB: lane addr[1:0] takes i_st_data[7:0].
  - SH: lanes {addr[1],0} and {addr[1],1}.
  - SW: all four lanes.
- Load extension:
  - B and H sign-extend from bit 7 and bit 15 of the selected lane.
  - BU and HU zero-extend.
  - W passes the word through.
  - op 011/110/111 is treated as W. The decoder never issues these values for loads.
- o_ld_data is valid regardless of i_lsu_wren. The write-back mux decides whether it is used.

## Timing
- Loads: combinational, zero latency, ready in the same cycle as the address.
- Stores: committed on the rising edge of i_clk while i_lsu_wren=1 and i_rst_n=1.
- Read during a store cycle returns the pre-store value. The new value is visible the next cycle.
- Reset value of all outputs:
  - o_io_ledr, o_io_ledg, o_io_hexl, o_io_hexh, o_io_lcd = 0, asynchronously on i_rst_n=0;
  - o_misalign and o_ld_data follow their combinational inputs.
- DMEM contents are not reset.
- While i_rst_n=0, no store commits, including a store whose edge coincides with reset assertion.
- On reset deassertion mid-instruction, the first rising edge with i_rst_n=1 may commit a store.

## Configuration
- LSU_SYNC_IN_EN defined:
  - i_io_sw and i_io_btn pass through a two-flop synchronizer before the read mux;
  - sync flops reset to 0;
  - input-to-load latency is 2 cycles.
- LSU_SYNC_IN_EN undefined: inputs feed the read mux directly, with 0-cycle latency.

## Structure
- lsu_pkg holds:
  - address constants: DMEM base/limit and each I/O address;
  - typedef enum logic [2:0] for load/store width: LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU.
- Sub-module dmem: byte-enabled DMEM_WORDS x 32 array.
  - Asynchronous read port.
  - Synchronous write port with a 4-bit byte-enable.
  - Instantiated once inside lsu.

## Test plan
- Reset with i_rst_n=0 after LED writes -> all five output registers read 0 immediately, with no clock edge needed.
- SW 0xDEADBEEF to 0x2004, then LB at 0x2007 -> 0xFFFFFFDE; LBU -> 0x000000DE; LH at 0x2006 -> 0xFFFFDEAD; LW -> 0xDEADBEEF.
- SH 0x1234 to 0x7002 on LEDR = 0 -> o_io_ledr = 0x12340000; a following SB 0xAA to 0x7000 -> 0x123400AA.
- LW at 0x2002 with wren, data 0x55 -> o_misalign=1, DMEM word 0x2000 unchanged, o_ld_data=0.
- Store to 0x7800 and to 0x5000 -> no register changes. LW at 0x7800 with i_io_sw=0xA5A5 -> 0x0000A5A5: same cycle without LSU_SYNC_IN_EN, after 2 cycles with it.
- Store and load the same DMEM address in one cycle -> old data in that cycle, new data the next cycle.
